// File: rtl/mdu_iter.sv
// mdu_iter: E-stage multiply/divide unit owning HI/LO, with an iterative radix-2 divider.
// Define MDU_MADD_EN to decode MADD/MADDU/MSUB/MSUBU (ops 7-10); otherwise those ops are NOPs.
module mdu_iter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_LAT = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int unsigned      CNT_MAX  = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
   localparam int unsigned      CNT_W    = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;
   typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_e;
   typedef enum logic [3:0] {
      OP_NOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO,
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
   } op_e;

   state_e             state_q, state_d;
   acc_e               acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic               dvd_neg_q, dvd_neg_d, dvs_neg_q, dvs_neg_d, div0_q, div0_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               busy_q, busy_d, done_q, done_d;

   logic               accept, mul_sgn, div_sgn;
   logic [2*WIDTH-1:0] mul_a, mul_b;
   logic [WIDTH:0]     rem_w, rem_diff;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      prod_d    = prod_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      dvd_neg_d = dvd_neg_q;
      dvs_neg_d = dvs_neg_q;
      div0_d    = div0_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;

      accept   = start && !flush && (state_q == S_IDLE);
      mul_sgn  = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
      div_sgn  = (op == OP_DIV);
      mul_a    = mul_sgn ? {{WIDTH{d1[WIDTH-1]}}, d1} : {{WIDTH{1'b0}}, d1};
      mul_b    = mul_sgn ? {{WIDTH{d2[WIDTH-1]}}, d2} : {{WIDTH{1'b0}}, d2};
      rem_w    = {rem_q, quo_q[WIDTH-1]};
      rem_diff = rem_w - {1'b0, dvs_q};

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     prod_d  = mul_a * mul_b;
                     acc_d   = ACC_NONE;
                     cnt_d   = CNT_ONE;
                     state_d = S_MUL;
                  end
`ifdef MDU_MADD_EN
                  OP_MADD, OP_MADDU: begin
                     prod_d  = mul_a * mul_b;
                     acc_d   = ACC_ADD;
                     cnt_d   = CNT_ONE;
                     state_d = S_MUL;
                  end
                  OP_MSUB, OP_MSUBU: begin
                     prod_d  = mul_a * mul_b;
                     acc_d   = ACC_SUB;
                     cnt_d   = CNT_ONE;
                     state_d = S_MUL;
                  end
`endif
                  OP_DIV, OP_DIVU: begin
                     // Divide magnitudes; the signs are reapplied in FIX.
                     dvd_neg_d = div_sgn & d1[WIDTH-1];
                     dvs_neg_d = div_sgn & d2[WIDTH-1];
                     quo_d     = (div_sgn && d1[WIDTH-1]) ? -d1 : d1;
                     dvs_d     = (div_sgn && d2[WIDTH-1]) ? -d2 : d2;
                     rem_d     = '0;
                     div0_d    = (d2 == '0);
                     cnt_d     = '0;
                     state_d   = S_DIV;
                  end
                  OP_MTHI: hi_d = d1;
                  OP_MTLO: lo_d = d1;
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (cnt_q == MUL_LAST) begin
               case (acc_q)
                  ACC_ADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
                  ACC_SUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_q;
                  default: {hi_d, lo_d} = prod_q;
               endcase
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_DIV: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               // A zero divisor naturally yields all-ones quotient and rem = |dividend|.
               if (!rem_diff[WIDTH]) begin
                  rem_d = rem_diff[WIDTH-1:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = rem_w[WIDTH-1:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b0};
               end
               if (cnt_q == DIV_LAST) state_d = S_FIX;
               else                   cnt_d   = cnt_q + CNT_ONE;
            end
         end
         S_FIX: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               lo_d    = div0_q ? '1 : ((dvd_neg_q ^ dvs_neg_q) ? -quo_q : quo_q);
               hi_d    = dvd_neg_q ? -rem_q : rem_q;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         acc_q     <= ACC_NONE;
         cnt_q     <= '0;
         prod_q    <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         dvd_neg_q <= 1'b0;
         dvs_neg_q <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         prod_q    <= prod_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         dvd_neg_q <= dvd_neg_d;
         dvs_neg_q <= dvs_neg_d;
         div0_q    <= div0_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule
